// File: rtl/fc_pkg.sv
// Shared types for the FC activation stage: default widths, arg-max states and FIFO entry.
package fc_pkg;

  localparam int FC_DATA_WIDTH = 8;
  localparam int FC_IDX_WIDTH  = 7;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FRAME = 2'd1,
    S_DONE  = 2'd2
  } argmax_state_t;

  typedef struct packed {
    logic                     last;
    logic [FC_IDX_WIDTH-1:0]  idx;
    logic [FC_DATA_WIDTH-1:0] data;
  } fc_act_entry_t;

endpackage

// File: rtl/fc_act_fifo.sv
// Synchronous FIFO of activation entries with a fall-through head (head valid whenever not empty).
module fc_act_fifo
  import fc_pkg::*;
#(
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  fc_act_entry_t wdata,
  input  logic          pop,
  output fc_act_entry_t head,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  fc_act_entry_t mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop && !empty;
  // A pop frees a slot in the same cycle, so a push into a full FIFO is legal then.
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= wdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/fc_activation.sv
// FC activation stage: optional ReLU, output FIFO with valid/ready, per-frame arg-max tracking.
// DATA_WIDTH/IDX_WIDTH must match the widths of fc_pkg::fc_act_entry_t.
module fc_activation
  import fc_pkg::*;
#(
  parameter int DATA_WIDTH = FC_DATA_WIDTH,
  parameter int IDX_WIDTH  = FC_IDX_WIDTH,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  relu_en_i,
  input  logic                  fc_valid_i,
  input  logic                  fc_last_i,
  input  logic [DATA_WIDTH-1:0] fc_result_i,
  output logic                  act_valid_o,
  input  logic                  act_ready_i,
  output logic [DATA_WIDTH-1:0] act_data_o,
  output logic                  act_last_o,
  output logic [IDX_WIDTH-1:0]  act_idx_o,
  output logic                  argmax_valid_o,
  output logic [IDX_WIDTH-1:0]  argmax_idx_o,
  output logic [DATA_WIDTH-1:0] argmax_val_o,
  output logic                  overflow_o
);

  localparam logic signed [DATA_WIDTH-1:0] BEST_RESET = {1'b1, {(DATA_WIDTH-1){1'b0}}};

  argmax_state_t                 state;
  argmax_state_t                 state_next;
  logic signed [DATA_WIDTH-1:0]  best_val;
  logic signed [DATA_WIDTH-1:0]  best_val_next;
  logic [IDX_WIDTH-1:0]          best_idx;
  logic [IDX_WIDTH-1:0]          best_idx_next;
  logic [IDX_WIDTH-1:0]          idx_cnt;
  logic                          relu_lat;
  logic                          relu_eff;
  logic [DATA_WIDTH-1:0]         act_val;
  logic                          pop;
  logic                          accept;
  logic                          drop;
  logic                          frame_end;
  fc_act_entry_t                 wr_entry;
  fc_act_entry_t                 head;
  logic                          full;
  logic                          empty;
  logic [$clog2(FIFO_DEPTH):0]   count;
  logic                          count_unused;

  assign count_unused = ^count;

  assign act_valid_o = !empty;
  assign pop         = act_valid_o && act_ready_i;
  assign accept      = fc_valid_i && (!full || pop);
  assign drop        = fc_valid_i && !accept;
  // A dropped last sample still closes the frame so frames stay aligned.
  assign frame_end   = fc_valid_i && fc_last_i;

  // The index-0 sample uses the live enable; later samples use the latched one.
  assign relu_eff = (idx_cnt == '0) ? relu_en_i : relu_lat;
  assign act_val  = (relu_eff && fc_result_i[DATA_WIDTH-1]) ? '0 : fc_result_i;

  assign wr_entry = '{last: fc_last_i, idx: idx_cnt, data: act_val};

  fc_act_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fc_valid_i),
    .wdata (wr_entry),
    .pop   (pop),
    .head  (head),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  assign act_data_o = empty ? '0 : head.data;
  assign act_last_o = empty ? 1'b0 : head.last;
  assign act_idx_o  = empty ? '0 : head.idx;

  assign argmax_valid_o = (state == S_DONE);

  always_comb begin
    state_next    = state;
    best_val_next = best_val;
    best_idx_next = best_idx;
    case (state)
      S_FRAME: begin
        if (accept && ($signed(act_val) > best_val)) begin
          best_val_next = $signed(act_val);
          best_idx_next = idx_cnt;
        end
        if (frame_end) begin
          state_next = S_DONE;
        end
      end
      default: begin
        // S_IDLE and S_DONE: a sample here starts a new frame.
        best_val_next = BEST_RESET;
        best_idx_next = '0;
        state_next    = S_IDLE;
        if (accept) begin
          best_val_next = $signed(act_val);
          best_idx_next = idx_cnt;
          state_next    = fc_last_i ? S_DONE : S_FRAME;
        end else if (frame_end) begin
          state_next = S_DONE;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= S_IDLE;
      best_val     <= BEST_RESET;
      best_idx     <= '0;
      argmax_idx_o <= '0;
      argmax_val_o <= '0;
    end else begin
      state    <= state_next;
      best_val <= best_val_next;
      best_idx <= best_idx_next;
      if (state_next == S_DONE) begin
        argmax_idx_o <= best_idx_next;
        argmax_val_o <= best_val_next;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_cnt    <= '0;
      relu_lat   <= 1'b0;
      overflow_o <= 1'b0;
    end else begin
      if (frame_end) begin
        idx_cnt <= '0;
      end else if (accept) begin
        idx_cnt <= idx_cnt + 1'b1;
      end
      if (accept && (idx_cnt == '0)) begin
        relu_lat <= relu_en_i;
      end
      if (drop) begin
        overflow_o <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fc_activation.sv
// Scoreboard bench for fc_activation: directed frames, expected entries and arg-max results queued at issue.
module tb_fc_activation;
  import fc_pkg::*;

  typedef struct packed {
    logic [6:0] idx;
    logic [7:0] val;
  } am_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       relu_en_i = 1'b0;
  logic       fc_valid_i = 1'b0;
  logic       fc_last_i = 1'b0;
  logic [7:0] fc_result_i = '0;
  logic       act_valid_o;
  logic       act_ready_i = 1'b0;
  logic [7:0] act_data_o;
  logic       act_last_o;
  logic [6:0] act_idx_o;
  logic       argmax_valid_o;
  logic [6:0] argmax_idx_o;
  logic [7:0] argmax_val_o;
  logic       overflow_o;

  int n_checks = 0;
  int n_fail   = 0;

  fc_act_entry_t exp_q[$];
  am_t           am_q[$];
  fc_act_entry_t mon_e;
  am_t           mon_a;

  fc_activation #(.DATA_WIDTH(8), .IDX_WIDTH(7), .FIFO_DEPTH(16)) dut (
    .clk            (clk),
    .rst            (rst),
    .relu_en_i      (relu_en_i),
    .fc_valid_i     (fc_valid_i),
    .fc_last_i      (fc_last_i),
    .fc_result_i    (fc_result_i),
    .act_valid_o    (act_valid_o),
    .act_ready_i    (act_ready_i),
    .act_data_o     (act_data_o),
    .act_last_o     (act_last_o),
    .act_idx_o      (act_idx_o),
    .argmax_valid_o (argmax_valid_o),
    .argmax_idx_o   (argmax_idx_o),
    .argmax_val_o   (argmax_val_o),
    .overflow_o     (overflow_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: compares the FIFO head against the queue front every valid cycle (stall stability
  // included) and pops when the transfer will happen on the coming edge.
  always @(negedge clk) begin
    if (!rst) begin
      if (act_valid_o) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_act_valid", 32'(act_valid_o), 32'd0);
        end else begin
          mon_e = exp_q[0];
          chk("act_data", 32'(act_data_o), 32'(mon_e.data));
          chk("act_idx",  32'(act_idx_o),  32'(mon_e.idx));
          chk("act_last", 32'(act_last_o), 32'(mon_e.last));
          if (act_ready_i) begin
            void'(exp_q.pop_front());
          end
        end
      end
      if (argmax_valid_o) begin
        if (am_q.size() == 0) begin
          chk("unexpected_argmax_valid", 32'(argmax_valid_o), 32'd0);
        end else begin
          mon_a = am_q.pop_front();
          chk("argmax_idx", 32'(argmax_idx_o), 32'(mon_a.idx));
          chk("argmax_val", 32'(argmax_val_o), 32'(mon_a.val));
        end
      end
    end
  end

  task automatic send(input logic [7:0] d, input logic last, input logic relu,
                      input logic keep, input logic [6:0] eidx, input logic [7:0] ed);
    @(posedge clk); #1;
    fc_valid_i  = 1'b1;
    fc_result_i = d;
    fc_last_i   = last;
    relu_en_i   = relu;
    if (keep) exp_q.push_back(fc_act_entry_t'{last, eidx, ed});
  endtask

  task automatic idle(input int n);
    @(posedge clk); #1;
    fc_valid_i = 1'b0;
    fc_last_i  = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_ready(input logic r);
    @(posedge clk); #1;
    act_ready_i = r;
  endtask

  task automatic wait_drain(input string name);
    for (int i = 0; i < 300 && (exp_q.size() != 0 || am_q.size() != 0); i++) @(posedge clk);
    @(posedge clk); #1;
    chk({name, "_entries_left"}, 32'(exp_q.size()), 32'd0);
    chk({name, "_argmax_left"}, 32'(am_q.size()), 32'd0);
    chk({name, "_valid_low"}, 32'(act_valid_o), 32'd0);
  endtask

  task automatic chk_all_zero(input string name);
    chk({name, "_act_valid"}, 32'(act_valid_o), 32'd0);
    chk({name, "_act_data"}, 32'(act_data_o), 32'd0);
    chk({name, "_act_last"}, 32'(act_last_o), 32'd0);
    chk({name, "_act_idx"}, 32'(act_idx_o), 32'd0);
    chk({name, "_argmax_valid"}, 32'(argmax_valid_o), 32'd0);
    chk({name, "_argmax_idx"}, 32'(argmax_idx_o), 32'd0);
    chk({name, "_argmax_val"}, 32'(argmax_val_o), 32'd0);
    chk({name, "_overflow"}, 32'(overflow_o), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    #2;
    chk_all_zero("reset");
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    act_ready_i = 1'b1;

    // Basic ReLU frame
    am_q.push_back('{7'd2, 8'h7F});
    send(8'h05, 1'b0, 1'b1, 1'b1, 7'd0, 8'h05);
    send(8'hF0, 1'b0, 1'b1, 1'b1, 7'd1, 8'h00);
    send(8'h7F, 1'b0, 1'b1, 1'b1, 7'd2, 8'h7F);
    send(8'h80, 1'b1, 1'b1, 1'b1, 7'd3, 8'h00);
    idle(3);
    wait_drain("relu");

    // Pass-through with ties
    am_q.push_back('{7'd1, 8'hFF});
    send(8'hFD, 1'b0, 1'b0, 1'b1, 7'd0, 8'hFD);
    send(8'hFF, 1'b0, 1'b0, 1'b1, 7'd1, 8'hFF);
    send(8'hFF, 1'b0, 1'b0, 1'b1, 7'd2, 8'hFF);
    send(8'hF9, 1'b1, 1'b0, 1'b1, 7'd3, 8'hF9);
    idle(3);
    wait_drain("ties");

    // Backpressure: 10-node frame while stalled
    set_ready(1'b0);
    am_q.push_back('{7'd6, 8'h7E});
    send(8'h03, 1'b0, 1'b1, 1'b1, 7'd0, 8'h03);
    chk("latency_not_yet", 32'(act_valid_o), 32'd0);
    send(8'h90, 1'b0, 1'b1, 1'b1, 7'd1, 8'h00);
    chk("latency_one_cycle", 32'(act_valid_o), 32'd1);
    send(8'h40, 1'b0, 1'b1, 1'b1, 7'd2, 8'h40);
    send(8'h11, 1'b0, 1'b1, 1'b1, 7'd3, 8'h11);
    send(8'h40, 1'b0, 1'b1, 1'b1, 7'd4, 8'h40);
    send(8'h22, 1'b0, 1'b1, 1'b1, 7'd5, 8'h22);
    send(8'h7E, 1'b0, 1'b1, 1'b1, 7'd6, 8'h7E);
    send(8'h00, 1'b0, 1'b1, 1'b1, 7'd7, 8'h00);
    send(8'h7E, 1'b0, 1'b1, 1'b1, 7'd8, 8'h7E);
    send(8'h01, 1'b1, 1'b1, 1'b1, 7'd9, 8'h01);
    idle(6);
    set_ready(1'b1);
    wait_drain("backpressure");
    chk("backpressure_overflow", 32'(overflow_o), 32'd0);

    // Overflow: 18 samples into a stalled 16-deep FIFO
    set_ready(1'b0);
    am_q.push_back('{7'd15, 8'h10});
    for (int i = 0; i < 16; i++) begin
      send(8'(i + 1), 1'b0, 1'b0, 1'b1, 7'(i), 8'(i + 1));
    end
    send(8'h70, 1'b0, 1'b0, 1'b0, 7'd0, 8'h00);
    chk("overflow_before_drop", 32'(overflow_o), 32'd0);
    send(8'h71, 1'b1, 1'b0, 1'b0, 7'd0, 8'h00);
    chk("overflow_set", 32'(overflow_o), 32'd1);
    idle(4);
    set_ready(1'b1);
    wait_drain("overflow");
    chk("overflow_sticky", 32'(overflow_o), 32'd1);

    // Back-to-back frames; second starts in the arg-max pulse cycle
    am_q.push_back('{7'd0, 8'h08});
    am_q.push_back('{7'd1, 8'hFA});
    send(8'h08, 1'b0, 1'b1, 1'b1, 7'd0, 8'h08);
    send(8'hF0, 1'b1, 1'b0, 1'b1, 7'd1, 8'h00);
    send(8'hF0, 1'b0, 1'b0, 1'b1, 7'd0, 8'hF0);
    chk("b2b_argmax_pulse", 32'(argmax_valid_o), 32'd1);
    send(8'hFA, 1'b0, 1'b1, 1'b1, 7'd1, 8'hFA);
    send(8'h85, 1'b1, 1'b1, 1'b1, 7'd2, 8'h85);
    idle(3);
    wait_drain("b2b");

    // Mid-frame reset
    set_ready(1'b0);
    send(8'h11, 1'b0, 1'b0, 1'b1, 7'd0, 8'h11);
    send(8'h22, 1'b0, 1'b0, 1'b1, 7'd1, 8'h22);
    send(8'h33, 1'b0, 1'b0, 1'b1, 7'd2, 8'h33);
    @(posedge clk); #1;
    fc_valid_i = 1'b0;
    chk("pre_reset_valid", 32'(act_valid_o), 32'd1);
    #3;
    rst = 1'b1;
    exp_q.delete();
    #1;
    chk_all_zero("midreset");
    @(posedge clk);
    @(posedge clk);
    #3 rst = 1'b0;
    act_ready_i = 1'b1;
    am_q.push_back('{7'd0, 8'h81});
    send(8'h81, 1'b0, 1'b0, 1'b1, 7'd0, 8'h81);
    send(8'h80, 1'b1, 1'b0, 1'b1, 7'd1, 8'h80);
    idle(3);
    wait_drain("after_reset");
    chk("after_reset_overflow", 32'(overflow_o), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
